// File: rtl/control_word_sequencer_8259_pkg.sv
// -----------------------------------------------------------------------------
// control_word_pkg_8259
// Shared definitions for the 8259A control-word sequencer:
//   - state_e        : initialization / operation state machine encoding
//   - OCW2_*         : OCW2 R/SL/EOI command codes (data bits 7:5)
//   - *_BIT          : bit positions of ICW1, ICW4, OCW2/OCW3 fields
//   - write_kind_e   : classification of a decoded write cycle
//   - decode_write() : maps A0 and data onto write_kind_e
// -----------------------------------------------------------------------------
package control_word_pkg_8259;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } state_e;

  // OCW2 command codes, {R, SL, EOI}
  localparam logic [2:0] OCW2_AROT_CLR   = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_NOP        = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_AROT_SET   = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

  // ICW1 fields
  localparam int ICW1_IC4_BIT  = 0;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW1_SEL_BIT  = 4;

  // ICW4 fields
  localparam int ICW4_UPM_BIT  = 0;
  localparam int ICW4_AEOI_BIT = 1;
  localparam int ICW4_MS_BIT   = 2;
  localparam int ICW4_BUF_BIT  = 3;
  localparam int ICW4_SFNM_BIT = 4;

  // OCW2/OCW3 select (D3 with D4=0) and OCW3 fields
  localparam int OCW_SEL_BIT    = 3;
  localparam int OCW3_RIS_BIT   = 0;
  localparam int OCW3_RR_BIT    = 1;
  localparam int OCW3_POLL_BIT  = 2;
  localparam int OCW3_SMM_BIT   = 5;
  localparam int OCW3_ESMM_BIT  = 6;

  typedef enum logic [1:0] {
    WR_ICW1    = 2'd0,  // A0=0, D4=1
    WR_A0_HIGH = 2'd1,  // ICW2/3/4 or OCW1 depending on state
    WR_OCW2    = 2'd2,  // A0=0, D4=0, D3=0
    WR_OCW3    = 2'd3   // A0=0, D4=0, D3=1
  } write_kind_e;

  function automatic write_kind_e decode_write(input logic a0, input logic [7:0] d);
    write_kind_e kind;
    if (a0)                      kind = WR_A0_HIGH;
    else if (d[ICW1_SEL_BIT])    kind = WR_ICW1;
    else if (d[OCW_SEL_BIT])     kind = WR_OCW3;
    else                         kind = WR_OCW2;
    return kind;
  endfunction

endpackage

// File: rtl/control_word_sequencer_8259_if.sv
// -----------------------------------------------------------------------------
// control_word_sequencer_8259_if
// CPU write-cycle bundle from the bus-control front end.
//   write_strobe      : async level, high while a CPU write is in progress
//   address           : A0 of the write
//   internal_data_bus : latched write data, held after the write ends
// master = bus front end (drives), slave = sequencer (samples).
// -----------------------------------------------------------------------------
interface control_word_sequencer_8259_if;
  logic       write_strobe;
  logic       address;
  logic [7:0] internal_data_bus;

  modport master (output write_strobe, output address, output internal_data_bus);
  modport slave  (input  write_strobe, input  address, input  internal_data_bus);
endinterface

// File: rtl/control_word_sequencer_8259_sync.sv
// -----------------------------------------------------------------------------
// strobe_synchronizer_8259
// Two-flop synchronizer for the asynchronous write strobe plus a falling-edge
// detector. The fall pulse is high for exactly one cycle, in the cycle after
// the synchronized strobe drops, so the consumer acts on the 3rd rising edge
// after the raw strobe falls.
//   clock, reset    : system clock, async active-high reset
//   strobe_async_i  : raw write strobe
//   strobe_sync_o   : synchronized strobe level
//   strobe_fall_o   : one-cycle write-event pulse
// -----------------------------------------------------------------------------
module strobe_synchronizer_8259 (
  input  logic clock,
  input  logic reset,
  input  logic strobe_async_i,
  output logic strobe_sync_o,
  output logic strobe_fall_o
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;

  // NOTE: every flop here is cleared by reset, so a strobe that is high at
  // reset assertion cannot leave a stale edge that fires after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give a true shift chain; blocking
      // would collapse the three stages into one.
      meta_q     <= strobe_async_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
    end
  end

  assign strobe_sync_o = sync_q;
  assign strobe_fall_o = sync_dly_q & ~sync_q;

endmodule

// File: rtl/control_word_sequencer_8259.sv
// -----------------------------------------------------------------------------
// control_word_sequencer_8259
// Turns 8259A write cycles into the ICW1..ICW4 initialization sequence and
// the OCW1..OCW3 operation commands. Holds all configuration registers and
// emits single-cycle command pulses.
//   clock, reset         : system clock, async active-high reset
//   bus (slave)          : write_strobe / address / internal_data_bus
//   initialization_done  : high in READY
//   ICW outputs          : interrupt_vector_base, level_or_edge_triggered,
//                          single_mode, cascade_config, special_fully_nested,
//                          buffered_mode, buffered_master, auto_eoi,
//                          microprocessor_mode_8086
//   OCW state            : interrupt_mask, auto_rotate_mode,
//                          special_mask_mode, read_register_isr,
//                          command_level
//   pulses               : eoi_command, specific_command, rotate_command,
//                          set_priority_command, poll_command
// -----------------------------------------------------------------------------
module control_word_sequencer_8259
  import control_word_pkg_8259::*;
(
  input  logic                          clock,
  input  logic                          reset,
  control_word_sequencer_8259_if.slave  bus,
  output logic                          initialization_done,
  output logic [4:0]                    interrupt_vector_base,
  output logic                          level_or_edge_triggered,
  output logic                          single_mode,
  output logic [7:0]                    cascade_config,
  output logic                          special_fully_nested,
  output logic                          buffered_mode,
  output logic                          buffered_master,
  output logic                          auto_eoi,
  output logic                          microprocessor_mode_8086,
  output logic [7:0]                    interrupt_mask,
  output logic                          auto_rotate_mode,
  output logic                          special_mask_mode,
  output logic                          read_register_isr,
  output logic                          eoi_command,
  output logic                          specific_command,
  output logic                          rotate_command,
  output logic                          set_priority_command,
  output logic [2:0]                    command_level,
  output logic                          poll_command
);

  logic        strobe_sync;
  logic        write_event;
  write_kind_e write_kind;

  state_e      state_q;
  logic        addr_q;
  logic [7:0]  data_q;
  logic        ic4_q;
  logic        init_done_q;
  logic [4:0]  vector_base_q;
  logic        ltim_q;
  logic        sngl_q;
  logic [7:0]  cascade_q;
  logic        sfnm_q;
  logic        buf_q;
  logic        ms_q;
  logic        aeoi_q;
  logic        upm_q;
  logic [7:0]  mask_q;
  logic        arot_q;
  logic        smm_q;
  logic        ris_q;
  logic        eoi_q;
  logic        specific_q;
  logic        rotate_q;
  logic        set_pri_q;
  logic [2:0]  level_q;
  logic        poll_q;

  strobe_synchronizer_8259 u_strobe_sync (
    .clock          (clock),
    .reset          (reset),
    .strobe_async_i (bus.write_strobe),
    .strobe_sync_o  (strobe_sync),
    .strobe_fall_o  (write_event)
  );

  // Decoded from the captured values, which are stable once the strobe drops.
  assign write_kind = decode_write(addr_q, data_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= 1'b0;
      data_q        <= '0;
      ic4_q         <= 1'b0;
      init_done_q   <= 1'b0;
      vector_base_q <= '0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      cascade_q     <= '0;
      sfnm_q        <= 1'b0;
      buf_q         <= 1'b0;
      ms_q          <= 1'b0;
      aeoi_q        <= 1'b0;
      upm_q         <= 1'b0;
      mask_q        <= '0;
      arot_q        <= 1'b0;
      smm_q         <= 1'b0;
      ris_q         <= 1'b0;
      eoi_q         <= 1'b0;
      specific_q    <= 1'b0;
      rotate_q      <= 1'b0;
      set_pri_q     <= 1'b0;
      level_q       <= '0;
      poll_q        <= 1'b0;
    end else begin
      // Command pulses default low so each one lasts a single cycle.
      eoi_q      <= 1'b0;
      specific_q <= 1'b0;
      rotate_q   <= 1'b0;
      set_pri_q  <= 1'b0;
      poll_q     <= 1'b0;

      // Track the bus while the write is in progress; the last captured
      // values are the ones the write event decodes.
      if (strobe_sync) begin
        addr_q <= bus.address;
        data_q <= bus.internal_data_bus;
      end

      if (write_event) begin
        if (write_kind == WR_ICW1) begin
          // ICW1 restarts initialization from any state.
          ltim_q      <= data_q[ICW1_LTIM_BIT];
          sngl_q      <= data_q[ICW1_SNGL_BIT];
          ic4_q       <= data_q[ICW1_IC4_BIT];
          mask_q      <= '0;
          smm_q       <= 1'b0;
          ris_q       <= 1'b0;
          arot_q      <= 1'b0;
          init_done_q <= 1'b0;
          if (!data_q[ICW1_IC4_BIT]) begin
            sfnm_q <= 1'b0;
            buf_q  <= 1'b0;
            ms_q   <= 1'b0;
            aeoi_q <= 1'b0;
            upm_q  <= 1'b0;
          end
          state_q <= ST_WAIT_ICW2;
        end else begin
          unique case (state_q)
            ST_WAIT_ICW2: begin
              if (write_kind == WR_A0_HIGH) begin
                vector_base_q <= data_q[7:3];
                if (!sngl_q) begin
                  state_q <= ST_WAIT_ICW3;
                end else if (ic4_q) begin
                  state_q <= ST_WAIT_ICW4;
                end else begin
                  state_q     <= ST_READY;
                  init_done_q <= 1'b1;
                end
              end
            end
            ST_WAIT_ICW3: begin
              if (write_kind == WR_A0_HIGH) begin
                cascade_q <= data_q;
                if (ic4_q) begin
                  state_q <= ST_WAIT_ICW4;
                end else begin
                  state_q     <= ST_READY;
                  init_done_q <= 1'b1;
                end
              end
            end
            ST_WAIT_ICW4: begin
              if (write_kind == WR_A0_HIGH) begin
                sfnm_q      <= data_q[ICW4_SFNM_BIT];
                buf_q       <= data_q[ICW4_BUF_BIT];
                ms_q        <= data_q[ICW4_MS_BIT];
                aeoi_q      <= data_q[ICW4_AEOI_BIT];
                upm_q       <= data_q[ICW4_UPM_BIT];
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
              end
            end
            ST_READY: begin
              unique case (write_kind)
                WR_A0_HIGH: mask_q <= data_q;
                WR_OCW2: begin
                  level_q <= data_q[2:0];
                  case (data_q[7:5])
                    OCW2_NS_EOI:     eoi_q <= 1'b1;
                    OCW2_SP_EOI: begin
                      eoi_q      <= 1'b1;
                      specific_q <= 1'b1;
                    end
                    OCW2_ROT_NS_EOI: begin
                      eoi_q    <= 1'b1;
                      rotate_q <= 1'b1;
                    end
                    OCW2_ROT_SP_EOI: begin
                      eoi_q      <= 1'b1;
                      rotate_q   <= 1'b1;
                      specific_q <= 1'b1;
                    end
                    OCW2_AROT_SET:   arot_q <= 1'b1;
                    OCW2_AROT_CLR:   arot_q <= 1'b0;
                    OCW2_SET_PRI: begin
                      set_pri_q  <= 1'b1;
                      specific_q <= 1'b1;
                    end
                    OCW2_NOP:        ;
                    default:         ;
                  endcase
                end
                WR_OCW3: begin
                  // ESMM/RR act as write enables for SMM/RIS.
                  if (data_q[OCW3_ESMM_BIT]) smm_q <= data_q[OCW3_SMM_BIT];
                  if (data_q[OCW3_RR_BIT])   ris_q <= data_q[OCW3_RIS_BIT];
                  if (data_q[OCW3_POLL_BIT]) poll_q <= 1'b1;
                end
                default: ;
              endcase
            end
            default: ;  // IDLE ignores everything but ICW1
          endcase
        end
      end
    end
  end

  assign initialization_done      = init_done_q;
  assign interrupt_vector_base    = vector_base_q;
  assign level_or_edge_triggered  = ltim_q;
  assign single_mode              = sngl_q;
  assign cascade_config           = cascade_q;
  assign special_fully_nested     = sfnm_q;
  assign buffered_mode            = buf_q;
  assign buffered_master          = ms_q;
  assign auto_eoi                 = aeoi_q;
  assign microprocessor_mode_8086 = upm_q;
  assign interrupt_mask           = mask_q;
  assign auto_rotate_mode         = arot_q;
  assign special_mask_mode        = smm_q;
  assign read_register_isr        = ris_q;
  assign eoi_command              = eoi_q;
  assign specific_command         = specific_q;
  assign rotate_command           = rotate_q;
  assign set_priority_command     = set_pri_q;
  assign command_level            = level_q;
  assign poll_command             = poll_q;

endmodule
